id_checksum_validator: RTL

//   Serial identity-code validator, parametrised successor of the 10-symbol ID checker.
//   - Accepts one symbol per cycle and validates the frame's mod-10 check digit.
//   - Modes: weighted letter-prefixed ID (mode 0) or Luhn (mode 1).
//   - Configurable frame length; accepts back-to-back frames; detects bad symbols and aborted frames.
//   - Sits between the serial ID input interface and the downstream verdict consumer.

---
 rtl/id_checksum_validator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/id_checksum_validator.sv
// Serial ID validator: one symbol per cycle, mod-10 check digit in weighted-ID or Luhn mode.
// Accumulator is kept reduced mod 10; verdict, abort and symbol-error flags are registered.
module id_checksum_validator #(
    parameter int NUM_DIGITS = 10,
    parameter int DIGIT_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_id,
    input  logic               in_mode,
    output logic               out_valid,
    output logic               out_legal_id,
    output logic               out_err
);

    localparam int   W     = NUM_DIGITS - 1;
    localparam int   CW    = $clog2(NUM_DIGITS);
    localparam logic W_ODD = 1'(W % 2);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [3:0]     acc, acc_n;
    logic           mode, mode_n;
    logic           err, err_n;
    logic           valid_d, legal_d, err_d;

    logic           first;
    logic           eff_mode;
    logic [5:0]     sym_lo;
    logic [5:0]     letter_hi;
    logic [5:0]     letter_lo;
    logic           digit_ok;
    logic           letter_ok;
    logic           sym_bad;
    logic           doubled;
    logic [3:0]     weight;
    logic [7:0]     dbl;
    logic [7:0]     term;
    logic [3:0]     term_mod;
    logic [3:0]     acc_base;
    logic [4:0]     sum5;
    logic [3:0]     acc_next;
    logic           err_total;
    logic           last_sym;
    logic           abort;

    // Per-symbol contribution, reduced mod 10 before it reaches the accumulator
    always_comb begin
        first     = (state == IDLE);
        eff_mode  = first ? in_mode : mode;
        sym_lo    = in_id[5:0];
        letter_hi = sym_lo / 6'd10;
        letter_lo = sym_lo % 6'd10;
        digit_ok  = (in_id <= DIGIT_W'(9));
        letter_ok = (in_id >= DIGIT_W'(10)) && (in_id <= DIGIT_W'(35));
        sym_bad   = (!eff_mode && first) ? !letter_ok : !digit_ok;
        doubled   = cnt[0] ^ W_ODD;
        weight    = (cnt == CW'(W)) ? 4'd1 : 4'(W - int'(cnt));
        dbl       = {3'b000, sym_lo[3:0], 1'b0};
        term      = 8'd0;
        if (!eff_mode) begin
            if (first) begin
                term = 8'(letter_hi) + 8'(letter_lo) * 8'(W);
            end else begin
                term = 8'(sym_lo[3:0]) * 8'(weight);
            end
        end else if (doubled) begin
            term = (dbl > 8'd9) ? (dbl - 8'd9) : dbl;
        end else begin
            term = 8'(sym_lo[3:0]);
        end
        term_mod  = 4'(term % 8'd10);
        acc_base  = first ? 4'd0 : acc;
        sum5      = {1'b0, acc_base} + {1'b0, term_mod};
        acc_next  = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
        err_total = (first ? 1'b0 : err) | sym_bad;
        last_sym  = (state == COLLECT) && in_valid && (cnt == CW'(W));
        abort     = (state == COLLECT) && !in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= 4'd0;
            mode         <= 1'b0;
            err          <= 1'b0;
            out_valid    <= 1'b0;
            out_legal_id <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            acc          <= acc_n;
            mode         <= mode_n;
            err          <= err_n;
            out_valid    <= valid_d;
            out_legal_id <= legal_d;
            out_err      <= err_d;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        mode_n  = mode;
        err_n   = err;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    mode_n  = in_mode;
                    cnt_n   = CW'(1);
                    acc_n   = acc_next;
                    err_n   = sym_bad;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (!in_valid || last_sym) begin
                    cnt_n   = '0;
                    acc_n   = 4'd0;
                    err_n   = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt + CW'(1);
                    acc_n   = acc_next;
                    err_n   = err_total;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Legal and error are mutually exclusive by construction
    always_comb begin
        valid_d = last_sym | abort;
        legal_d = last_sym && !err_total && (acc_next == 4'd0);
        err_d   = abort | (last_sym && err_total);
    end

endmodule
